// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types and field helpers for the memory port arbiter
package mem_arb_pkg;

  // Tag id is sized for up to 256 requesters; unused upper bits stay zero.
  localparam int ID_W    = 8;
  localparam int VEC_W   = 1024;
  localparam int FIELD_W = 64;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;

  // Extract field idx of width w from a packed per-requester vector.
  function automatic logic [FIELD_W-1:0] field_at(input logic [VEC_W-1:0] vec,
                                                  input int idx, input int w);
    logic [FIELD_W-1:0] mask;
    mask = (FIELD_W'(1) << w) - FIELD_W'(1);
    return FIELD_W'(vec >> (idx * w)) & mask;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// rtl/mem_port_arbiter_rr_pick.sv - combinational round-robin picker starting at a given index
module rr_pick #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  valid_i,
  input  logic [IW-1:0] start_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o
);

  logic found;
  int   pos;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    pos     = 0;
    for (int k = 0; k < N; k++) begin
      pos = (int'(start_i) + k) % N;
      if (!found && valid_i[pos]) begin
        found        = 1'b1;
        grant_o[pos] = 1'b1;
        idx_o        = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin bounded-burst arbiter sharing one memory port
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 16,
  parameter int LENGTH   = 32,
  parameter int DELAY    = 1,
  parameter int MAXBURST = 2,
  localparam int AW      = $clog2(LENGTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NREQ-1:0]       reqValid_i,
  output logic [NREQ-1:0]       reqReady_o,
  input  logic [NREQ-1:0]       reqWr_i,
  input  logic [NREQ*AW-1:0]    reqAddr_i,
  input  logic [NREQ*WIDTH-1:0] reqData_i,
  output logic [NREQ-1:0]       rspValid_o,
  output logic [WIDTH-1:0]      rspData_o,
  output logic                  memEn_o,
  output logic                  memWr_o,
  output logic [AW-1:0]         memAddr_o,
  output logic [WIDTH-1:0]      memDataIn_o,
  input  logic [WIDTH-1:0]      memDataOut_i
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(MAXBURST + 1);

  logic [IW-1:0]   owner_q;
  logic [CW-1:0]   cnt_q;
  logic [IW-1:0]   start_idx;
  logic [IW-1:0]   pick_idx;
  logic [IW-1:0]   gnt_idx;
  logic [NREQ-1:0] pick_grant;
  logic [NREQ-1:0] grant;
  logic            granted;
  logic            keep_owner;
  tag_t            pipe_q [DELAY];
  tag_t            tag_in;
  tag_t            tag_out;

  // Search begins just past the owner, so the owner itself is tried last.
  assign start_idx = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + IW'(1);

  rr_pick #(.N(NREQ)) u_pick (
    .valid_i (reqValid_i),
    .start_i (start_idx),
    .grant_o (pick_grant),
    .idx_o   (pick_idx)
  );

  always_comb begin
    keep_owner = reqValid_i[owner_q] && (cnt_q < CW'(MAXBURST));
    grant      = '0;
    gnt_idx    = owner_q;
    if (rst_i) begin
      grant = '0;
    end else if (keep_owner) begin
      grant[owner_q] = 1'b1;
    end else begin
      grant   = pick_grant;
      gnt_idx = pick_idx;
    end
    granted = |grant;
  end

  assign reqReady_o  = grant;
  assign memEn_o     = granted;
  assign memWr_o     = granted & reqWr_i[gnt_idx];
  assign memAddr_o   = granted ? AW'(field_at(VEC_W'(reqAddr_i), int'(gnt_idx), AW)) : '0;
  assign memDataIn_o = granted ? WIDTH'(field_at(VEC_W'(reqData_i), int'(gnt_idx), WIDTH)) : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      owner_q <= IW'(NREQ - 1);
      cnt_q   <= CW'(MAXBURST);
    end else if (granted) begin
      if (gnt_idx == owner_q) begin
        if (cnt_q < CW'(MAXBURST)) cnt_q <= cnt_q + CW'(1);
      end else begin
        owner_q <= gnt_idx;
        cnt_q   <= CW'(1);
      end
    end
  end

  always_comb begin
    tag_in       = '0;
    tag_in.valid = granted && !memWr_o;
    tag_in.id    = ID_W'(gnt_idx);
  end

  // Tags march alongside the memory read latency; reset drops everything in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < DELAY; k++) pipe_q[k] <= '0;
    end else begin
      pipe_q[0] <= tag_in;
      for (int k = 1; k < DELAY; k++) pipe_q[k] <= pipe_q[k-1];
    end
  end

  assign tag_out = pipe_q[DELAY-1];

  always_comb begin
    rspValid_o = '0;
    rspData_o  = '0;
    if (tag_out.valid && !rst_i) begin
      rspData_o = memDataOut_i;
      for (int i = 0; i < NREQ; i++)
        if (tag_out.id == ID_W'(i)) rspValid_o[i] = 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int NREQ     = 4;
  localparam int WIDTH    = 16;
  localparam int LENGTH   = 32;
  localparam int DELAY    = 2;
  localparam int MAXBURST = 2;
  localparam int AW       = $clog2(LENGTH);
  localparam int BOUND    = (NREQ - 1) * MAXBURST;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NREQ-1:0]       reqValid = '0;
  logic [NREQ-1:0]       reqReady;
  logic [NREQ-1:0]       reqWr = '0;
  logic [NREQ*AW-1:0]    reqAddr = '0;
  logic [NREQ*WIDTH-1:0] reqData = '0;
  logic [NREQ-1:0]       rspValid;
  logic [WIDTH-1:0]      rspData;
  logic                  memEn, memWr;
  logic [AW-1:0]         memAddr;
  logic [WIDTH-1:0]      memDataIn, memDataOut;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  mem_port_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .LENGTH(LENGTH), .DELAY(DELAY),
                     .MAXBURST(MAXBURST)) dut (
    .clk_i(clk), .rst_i(rst), .reqValid_i(reqValid), .reqReady_o(reqReady),
    .reqWr_i(reqWr), .reqAddr_i(reqAddr), .reqData_i(reqData),
    .rspValid_o(rspValid), .rspData_o(rspData), .memEn_o(memEn), .memWr_o(memWr),
    .memAddr_o(memAddr), .memDataIn_o(memDataIn), .memDataOut_i(memDataOut)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory port model with DELAY-cycle read latency.
  logic [WIDTH-1:0] mem [LENGTH];
  logic [WIDTH-1:0] rd_line [DELAY];
  always @(posedge clk) begin
    if (memEn && memWr) mem[memAddr] <= memDataIn;
    rd_line[0] <= (memEn && !memWr) ? mem[memAddr] : '0;
    for (int k = 1; k < DELAY; k++) rd_line[k] <= rd_line[k-1];
  end
  assign memDataOut = rd_line[DELAY-1];

  function automatic logic [WIDTH-1:0] init_val(input int k);
    return WIDTH'(k * 16'h0101) ^ 16'h5A5A;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic w,
                         input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    reqValid[i] = v;
    reqWr[i] = w;
    reqAddr[i*AW +: AW] = a;
    reqData[i*WIDTH +: WIDTH] = d;
  endtask

  task automatic clear_all();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 1'b0, '0, '0);
  endtask

  // Scoreboard: reads push their expected response at acceptance.
  typedef struct {
    int due;
    int id;
    logic [WIDTH-1:0] data;
  } exp_t;
  exp_t sb_q[$];
  logic [WIDTH-1:0] shadow [LENGTH];
  int wait_cnt [NREQ];

  always @(negedge clk) begin
    logic [NREQ-1:0]  exp_v;
    logic [WIDTH-1:0] exp_d;
    logic [NREQ-1:0]  acc;
    exp_t e;
    if (rst) begin
      sb_q.delete();
      for (int i = 0; i < NREQ; i++) wait_cnt[i] = 0;
      chk("reset_quiet", {rspValid, rspData, reqReady, memEn}, '0);
    end else begin
      exp_v = '0;
      exp_d = '0;
      if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
        e = sb_q.pop_front();
        exp_v[e.id] = 1'b1;
        exp_d = e.data;
      end
      chk("rsp_valid", rspValid, exp_v);
      chk("rsp_data", rspData, exp_d);
      acc = reqValid & reqReady;
      chk("ready_onehot0", $onehot0(reqReady), 1);
      chk("ready_subset", reqReady & ~reqValid, 0);
      chk("mem_en", memEn, |acc);
      if (acc == '0) chk("mem_idle", {memWr, memAddr, memDataIn}, '0);
      for (int i = 0; i < NREQ; i++) begin
        if (acc[i]) begin
          chk("wait_bound", wait_cnt[i] <= BOUND, 1);
          wait_cnt[i] = 0;
          chk("mem_wr", memWr, reqWr[i]);
          chk("mem_addr", memAddr, reqAddr[i*AW +: AW]);
          if (reqWr[i]) begin
            chk("mem_wdata", memDataIn, reqData[i*WIDTH +: WIDTH]);
            shadow[reqAddr[i*AW +: AW]] = reqData[i*WIDTH +: WIDTH];
          end else begin
            e.due = cyc + DELAY;
            e.id = i;
            e.data = shadow[reqAddr[i*AW +: AW]];
            sb_q.push_back(e);
          end
        end else if (reqValid[i]) begin
          wait_cnt[i]++;
        end else begin
          wait_cnt[i] = 0;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [NREQ-1:0] v;
    logic [NREQ-1:0] w;
    logic [NREQ-1:0] exp;
  } vec_t;
  vec_t tbl [20];

  logic [NREQ-1:0]  rv, rwr, racc;
  logic [AW-1:0]    raddr [NREQ];
  logic [WIDTH-1:0] rdata [NREQ];

  initial begin
    tbl[0]  = '{4'b1111, 4'b1010, 4'b0001};
    tbl[1]  = '{4'b1111, 4'b1010, 4'b0001};
    tbl[2]  = '{4'b1111, 4'b1010, 4'b0010};
    tbl[3]  = '{4'b1111, 4'b1010, 4'b0010};
    tbl[4]  = '{4'b1111, 4'b0000, 4'b0100};
    tbl[5]  = '{4'b1111, 4'b0000, 4'b0100};
    tbl[6]  = '{4'b1111, 4'b0000, 4'b1000};
    tbl[7]  = '{4'b1111, 4'b0000, 4'b1000};
    tbl[8]  = '{4'b1111, 4'b0000, 4'b0001};
    tbl[9]  = '{4'b0000, 4'b0000, 4'b0000};
    tbl[10] = '{4'b1000, 4'b0000, 4'b1000};
    tbl[11] = '{4'b1000, 4'b1000, 4'b1000};
    tbl[12] = '{4'b1000, 4'b0000, 4'b1000};
    tbl[13] = '{4'b1001, 4'b0000, 4'b0001};
    tbl[14] = '{4'b1001, 4'b0001, 4'b0001};
    tbl[15] = '{4'b1001, 4'b0000, 4'b1000};
    tbl[16] = '{4'b0110, 4'b0000, 4'b0010};
    tbl[17] = '{4'b0100, 4'b0000, 4'b0100};
    tbl[18] = '{4'b0101, 4'b0000, 4'b0100};
    tbl[19] = '{4'b0101, 4'b0000, 4'b0001};

    for (int k = 0; k < LENGTH; k++) begin
      mem[k] = init_val(k);
      shadow[k] = init_val(k);
    end
    mem[5] = 16'hBEEF;
    shadow[5] = 16'hBEEF;
    for (int k = 0; k < DELAY; k++) rd_line[k] = '0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Single read of a preloaded word.
    @(posedge clk); #1 set_req(2, 1'b1, 1'b0, 5'd5, '0);
    @(negedge clk); chk("A_ready", reqReady, 4'b0100);
    @(posedge clk); #1 clear_all();
    for (int k = 1; k <= DELAY; k++) begin
      @(negedge clk);
      if (k == DELAY) begin
        chk("A_rsp_valid", rspValid, 4'b0100);
        chk("A_rsp_data", rspData, 16'hBEEF);
      end else begin
        chk("A_rsp_early", rspValid, 4'b0000);
      end
    end
    @(negedge clk); chk("A_rsp_once", rspValid, 4'b0000);

    // Write then read of the same address on consecutive cycles.
    @(posedge clk); #1 set_req(1, 1'b1, 1'b1, 5'd7, 16'h1234);
    @(negedge clk); chk("B_wr_ready", reqReady, 4'b0010);
    @(posedge clk); #1 clear_all(); set_req(0, 1'b1, 1'b0, 5'd7, '0);
    @(negedge clk); chk("B_rd_ready", reqReady, 4'b0001);
    @(posedge clk); #1 clear_all();
    for (int k = 2; k <= DELAY + 1; k++) begin
      @(negedge clk);
      if (k == DELAY + 1) begin
        chk("B_rsp_valid", rspValid, 4'b0001);
        chk("B_rsp_data", rspData, 16'h1234);
      end else begin
        chk("B_no_wr_rsp", rspValid, 4'b0000);
      end
    end

    // Back-to-back reads from three requesters.
    for (int c = 0; c < DELAY + 4; c++) begin
      @(posedge clk); #1 clear_all();
      if (c < 3) set_req(c, 1'b1, 1'b0, AW'(3 + c), '0);
      @(negedge clk);
      if (c < 3) chk("C_ready", reqReady, 4'(1 << c));
      if (c >= DELAY && c - DELAY < 3) begin
        chk("C_rsp_valid", rspValid, 4'(1 << (c - DELAY)));
        chk("C_rsp_data", rspData, (c - DELAY == 2) ? 16'hBEEF : init_val(3 + c - DELAY));
      end else begin
        chk("C_rsp_idle", rspValid, 4'b0000);
      end
    end

    // Reset while a read is in flight, then contention between 0 and 3.
    @(posedge clk); #1 set_req(2, 1'b1, 1'b0, 5'd4, '0);
    @(negedge clk); chk("D_ready", reqReady, 4'b0100);
    @(posedge clk); #1 rst = 1'b1; clear_all();
    set_req(0, 1'b1, 1'b0, 5'd3, '0); set_req(3, 1'b1, 1'b0, 5'd4, '0);
    @(negedge clk);
    chk("D_rst_ready", reqReady, 4'b0000);
    chk("D_rst_memen", memEn, 0);
    chk("D_rst_rsp", rspValid, 4'b0000);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("D_first_win", reqReady, 4'b0001);
    chk("D_dropped_rsp", rspValid, 4'b0000);
    @(posedge clk); #1 clear_all();
    repeat (DELAY + 2) @(negedge clk);

    // Table of grant patterns from a fresh reset.
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      for (int i = 0; i < NREQ; i++)
        set_req(i, tbl[n].v[i], tbl[n].w[i], AW'(16 + i), WIDTH'(16'hC000 + n * 16 + i));
      @(negedge clk);
      chk($sformatf("T%0d_ready", n), reqReady, tbl[n].exp);
    end
    @(posedge clk); #1 clear_all();
    repeat (DELAY + 2) @(negedge clk);

    // Protocol-compliant random traffic: fields held until accepted.
    rv = '0; rwr = '0; racc = '0;
    for (int i = 0; i < NREQ; i++) begin raddr[i] = '0; rdata[i] = '0; end
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      for (int i = 0; i < NREQ; i++) begin
        if (!rv[i] || racc[i]) begin
          rv[i] = ($urandom_range(0, 99) < 60);
          rwr[i] = ($urandom_range(0, 2) == 0);
          raddr[i] = AW'($urandom_range(0, LENGTH - 1));
          rdata[i] = WIDTH'($urandom);
        end
        set_req(i, rv[i], rwr[i], raddr[i], rdata[i]);
      end
      @(negedge clk);
      racc = reqValid & reqReady;
    end
    @(posedge clk); #1 clear_all();
    repeat (DELAY + 3) @(negedge clk);
    chk("sb_empty", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

- Shares one port of the dual-port simulation memory between NREQ requesters.
- Arbitration is round-robin with bounded bursts. Each accepted access is forwarded in the same cycle. Each read's data is routed back to its originator exactly DELAY cycles later.
- Sits between testbench/agent request streams and one memory port, so several masters can use a single port without external glue.

## Interface
Parameters:
- NREQ, 4, number of requesters (≥2)
- WIDTH, 16, data width; equals the memory WIDTH
- LENGTH, 32, memory words; address width AW = $clog2(LENGTH)
- DELAY, 1, memory read latency in cycles (≥1); equals the memory DELAY
- MAXBURST, 2, maximum consecutive grants to one requester while others wait (≥1)

Ports (one clock; reset is synchronous and active-high):
- clk_i  in  1  clock; also drives the memory port clock
- rst_i  in  1  synchronous active-high reset
- reqValid_i  in  NREQ  request valid, one bit per requester
- reqReady_o  out  NREQ  request accepted this cycle (one-hot or zero)
- reqWr_i  in  NREQ  1 = write, 0 = read
- reqAddr_i  in  NREQ*AW  packed addresses; requester i at [i*AW +: AW]
- reqData_i  in  NREQ*WIDTH  packed write data
- rspValid_o  out  NREQ  read data valid for requester i (one-hot or zero)
- rspData_o  out  WIDTH  read data, shared by all requesters
- memEn_o, memWr_o  out  1  memory port enable / write
- memAddr_o  out  AW  memory address
- memDataIn_o  out  WIDTH  memory write data
- memDataOut_i  in  WIDTH  memory read data

## Operation
- Request handshake:
  - A request transfers when reqValid_i[i] && reqReady_o[i].
  - reqValid_i must stay high with stable fields until accepted; the arbiter never backpressures beyond arbitration.
- Grant selection (combinational):
  - State: owner (0..NREQ-1) and beat count cnt (1..MAXBURST).
  - If reqValid_i[owner] && cnt < MAXBURST, grant owner.
  - Otherwise grant the first valid requester searching owner+1, owner+2, … with wrap-around. The search includes owner last.
- Forwarding:
  - memEn_o = any grant.
  - memWr_o, memAddr_o and memDataIn_o are muxed from the granted requester.
  - With no grant, memWr_o = 0 and the other memory outputs are 0.
- State update on a grant g:
  - If g == owner, cnt <= cnt+1.
  - Otherwise owner <= g and cnt <= 1.
  - With no grant, owner and cnt hold.
- Response tracking:
  - A DELAY-deep shift register of tags {valid, id} advances every cycle.
  - Entry 0 is loaded with {granted && !memWr_o, g}.
- Response output:
  - When the tag leaving the pipe is valid, rspValid_o[id] = 1 and rspData_o = memDataOut_i.
  - Otherwise rspValid_o = 0 and rspData_o = 0.
- Requesters must always accept responses; there is no response backpressure.
- Writes produce no response. A read and a write to the same address in consecutive cycles are ordered by acceptance order.

## Timing
- Grant and memory outputs follow reqValid_i combinationally. Accept and memory access happen in the same cycle t.
- Read accepted at cycle t: rspValid_o is high for exactly one cycle, in cycle t+DELAY.
- Throughput: one access per cycle; back-to-back reads are fully pipelined.
- Reset values:
  - owner = NREQ-1 and cnt = MAXBURST, so requester 0 wins first.
  - All tags invalid; rspValid_o = 0, rspData_o = 0.
  - While rst_i is high: reqReady_o = 0 and memEn_o = 0.
- Reset mid-operation: in-flight reads are dropped. No rspValid_o is raised for them, even though the memory still returns data.
- MAXBURST = 1 gives pure round-robin.
- With a single active requester it is granted every cycle; cnt saturates at MAXBURST, then the search wraps back to it.
- Simultaneous response and new grant to the same requester are legal and independent.

## Structure
- Package mem_arb_pkg holds:
  - the tag typedef {logic valid; logic [$clog2(NREQ)-1:0] id}, parameterised via localparam widths;
  - a function to unpack requester i fields from the packed vectors.
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: valid vector, start index.
  - Outputs: one-hot grant and grant index.
  - Instantiated once for the owner+1 search.
- Top level holds the owner/cnt registers, the tag shift register and the muxes. Target size is about 200 lines.

## Test plan
- Reset then a single read: mem preloaded [5]=0xBEEF; req 2 reads addr 5 at t → reqReady_o=4'b0100 at t; rspValid_o=4'b0100 and rspData_o=0xBEEF at t+DELAY; nothing else.
- All four requesters hold reads continuously, MAXBURST=2 → grant order 0,0,1,1,2,2,3,3,0,… and each response reaches the correct id.
- Interleaved write/read: req 1 writes 0x1234 to addr 7 at t, req 0 reads addr 7 at t+1 → response 0x1234 to req 0 only; the write gives no rspValid_o.
- DELAY=3: back-to-back reads from reqs 0,1,2 at t..t+2 → rspValid_o one-hot 0,1,2 at t+3..t+5 with matching data.
- Reset asserted at t+1 after a read at t (DELAY=2) → rspValid_o stays 0. After release, requester 0 wins the first contention against 3.
- Random valid/wr/addr traffic for 10k cycles against a scoreboard → no lost or duplicated response. Per requester, no wait exceeds (NREQ-1)*MAXBURST cycles.
